// File: rtl/pipe_int_ctrl.sv
// pipe_int_ctrl: interrupt entry/return sequencer (drain, vector, ISR, return) for an in-order pipeline.
// Build option: define INT_EDGE_EN to qualify interrupt on its 0->1 edge instead of its level.
module pipe_int_ctrl #(
  parameter logic [7:0]  ISR_VECTOR   = 8'hF0,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       interrupt,
  input  logic [7:0] current_address,
  input  logic       reti,
  input  logic       hold,
  output logic       stall_fetch,
  output logic       bubble,
  output logic       pc_load,
  output logic [7:0] pc_next,
  output logic [7:0] epc,
  output logic       in_isr,
  output logic       int_ack
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_DRAIN  = 3'd1,
    S_VECTOR = 3'd2,
    S_ISR    = 3'd3,
    S_RETURN = 3'd4
  } state_t;

  state_t     state, state_n;
  logic       pending;
  logic       settle;
  logic [2:0] cnt;
  logic       int_qual;
  logic       enter;
  logic       drain_done;

`ifdef INT_EDGE_EN
  logic int_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) int_prev <= 1'b0;
    else        int_prev <= interrupt;
  end

  assign int_qual = interrupt & ~int_prev;
`else
  assign int_qual = interrupt;
`endif

  // settle covers the return slot, so the RUN cycle after RETURN always fetches from epc
  assign enter      = (state == S_RUN) && pending && !settle;
  assign drain_done = (state == S_DRAIN) && !hold && (cnt == 3'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RUN;
      pending <= 1'b0;
      settle  <= 1'b0;
      cnt     <= '0;
      epc     <= '0;
    end else begin
      state   <= state_n;
      pending <= (pending && (state != S_VECTOR)) || int_qual;
      if (enter) begin
        epc <= current_address;
        cnt <= '0;
      end else if ((state == S_DRAIN) && !hold) begin
        cnt <= cnt + 3'd1;
      end
      if ((state == S_ISR) && reti)  settle <= 1'b1;
      else if (state == S_RETURN)    settle <= 1'b0;
    end
  end

  always_comb begin
    state_n     = state;
    stall_fetch = 1'b0;
    bubble      = 1'b0;
    pc_load     = 1'b0;
    pc_next     = '0;
    in_isr      = 1'b0;
    int_ack     = 1'b0;
    unique case (state)
      S_RUN: begin
        if (enter) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        stall_fetch = 1'b1;
        bubble      = 1'b1;
        if (drain_done) state_n = S_VECTOR;
      end
      S_VECTOR: begin
        pc_load = 1'b1;
        pc_next = ISR_VECTOR;
        int_ack = 1'b1;
        state_n = S_ISR;
      end
      S_ISR: begin
        in_isr = 1'b1;
        if (reti) state_n = S_RETURN;
      end
      S_RETURN: begin
        pc_load = 1'b1;
        pc_next = epc;
        bubble  = 1'b1;
        state_n = S_RUN;
      end
      default: state_n = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Randomized self-checking bench for pipe_int_ctrl against a cycle-level behavioural model.
module tb_pipe_int_ctrl;

  localparam logic [7:0]  ISR_V = 8'hF0;
  localparam int unsigned DRAIN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       interrupt = 1'b0;
  logic [7:0] current_address = '0;
  logic       reti = 1'b0;
  logic       hold = 1'b0;
  logic       stall_fetch, bubble, pc_load, in_isr, int_ack;
  logic [7:0] pc_next, epc;

  pipe_int_ctrl #(.ISR_VECTOR(ISR_V), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt), .current_address(current_address),
    .reti(reti), .hold(hold), .stall_fetch(stall_fetch), .bubble(bubble),
    .pc_load(pc_load), .pc_next(pc_next), .epc(epc), .in_isr(in_isr), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // {stall_fetch, bubble, pc_load, pc_next[7:0], epc[7:0], in_isr, int_ack}
  logic [20:0] dut_word;
  assign dut_word = {stall_fetch, bubble, pc_load, pc_next, epc, in_isr, int_ack};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remaining drain cycles, one-cycle vector/return slots, ISR flag.
  bit       m_pending, m_vec, m_isr, m_ret, m_prev;
  int       m_drain;
  bit [7:0] m_epc;

  function automatic logic [20:0] exp_word();
    logic       s;
    logic [7:0] pn;
    s  = (m_drain > 0);
    pn = m_vec ? ISR_V : (m_ret ? m_epc : 8'h00);
    return {s, s | m_ret, m_vec | m_ret, pn, m_epc, m_isr, m_vec};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_vec = 0; m_isr = 0; m_ret = 0; m_prev = 0; m_drain = 0; m_epc = 8'h00;
  endtask

  task automatic model_step();
    bit q, was_vec;
`ifdef INT_EDGE_EN
    q = interrupt && !m_prev;
`else
    q = interrupt;
`endif
    was_vec = m_vec;
    if (m_drain > 0) begin
      if (!hold) begin
        m_drain--;
        if (m_drain == 0) m_vec = 1;
      end
    end else if (m_vec) begin
      m_vec = 0; m_isr = 1;
    end else if (m_isr) begin
      if (reti) begin m_isr = 0; m_ret = 1; end
    end else if (m_ret) begin
      m_ret = 0;
    end else if (m_pending) begin
      m_epc   = current_address;
      m_drain = DRAIN;
    end
    m_pending = (m_pending && !was_vec) || q;
    m_prev    = interrupt;
  endtask

  logic [20:0] snap;

  task automatic tick();
    @(negedge clk);
    snap = dut_word;
    check("outs", dut_word, exp_word());
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    #1;
  endtask

  int n, acks;

  task automatic wait_ack(input string tag, input int exp_lat, input int hold_from, input int hold_len);
    n = 0;
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    do begin
      hold = (n >= hold_from) && (n < hold_from + hold_len);
      tick();
      n++;
    end while (!snap[0] && n < 30);
    hold = 1'b0;
    check(tag, n, exp_lat);
  endtask

  int burst;

  initial begin
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("reset_idle", dut_word, 21'h0);

    current_address = 8'h12;
    wait_ack("ack_latency", DRAIN + 2, 99, 0);
    check("vec_pc", snap[17:10], ISR_V);
    current_address = 8'h77;
    tick();
    check("epc_saved", epc, 8'h12);
    check("in_isr", in_isr, 1'b1);
    repeat (3) tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    tick();
    check("ret_pc", snap[17:10], 8'h12);
    check("ret_bubble", snap[19], 1'b1);
    repeat (4) tick();

    current_address = 8'h12;
    wait_ack("ack_hold", DRAIN + 4, 2, 2);
    repeat (2) tick();

    interrupt = 1'b1;
    reti = 1'b1;
    tick();
    interrupt = 1'b0;
    reti = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!snap[20] && n < 20);
    check("reentry_gap", n, 3);
    repeat (DRAIN + 3) tick();
    reti = 1'b1;
    tick();
    reti = 1'b0;
    repeat (4) tick();

    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_async", dut_word, 21'h0);
    acks = 0;
    repeat (3) begin tick(); acks += snap[0]; end
    reset = 1'b1;
    repeat (8) begin tick(); acks += snap[0]; end
    check("rst_no_ack", acks, 0);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 12);
      interrupt       = (burst > 0) || ($urandom_range(0, 24) == 0);
      reti            = ($urandom_range(0, 7) == 0);
      hold            = ($urandom_range(0, 3) == 0);
      current_address = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_int_ctrl.md
PIPE_INT_CTRL -- requirements
Module: pipe_int_ctrl

Interface
REQ-001 SHALL have parameter ISR_VECTOR, default 8'hF0, the instruction address loaded on interrupt entry.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3, the cycles needed to retire the EX, DM and WB stages; legal range 1..7.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port interrupt, input, 1, the external interrupt request.
REQ-006 SHALL have port current_address, input, 8, the PC of the next instruction to be fetched.
REQ-007 SHALL have port reti, input, 1, a one-cycle pulse when decode sees return-from-interrupt.
REQ-008 SHALL have port hold, input, 1, the pipeline memory stall; freezes the drain count.
REQ-009 SHALL have port stall_fetch, output, 1, which holds the PC and IF register.
REQ-010 SHALL have port bubble, output, 1, which injects a NOP into ID.
REQ-011 SHALL have port pc_load, output, 1, which forces the PC to pc_next.
REQ-012 SHALL have port pc_next, output, 8, the forced PC value.
REQ-013 SHALL have port epc, output, 8, the saved return address.
REQ-014 SHALL have port in_isr, output, 1, high while the ISR executes.
REQ-015 SHALL have port int_ack, output, 1, a one-cycle acknowledge pulse.

Function
REQ-016 SHALL implement states RUN, DRAIN, VECTOR, ISR and RETURN, encoded in 3 bits.
REQ-017 SHALL keep a pending flag that sets on a qualified interrupt (REQ-032) in any state and clears only in VECTOR.
REQ-018 In RUN with pending=1 and the settle flag clear, SHALL latch epc<=current_address, go to DRAIN and clear the drain counter.
REQ-019 In DRAIN, SHALL hold stall_fetch=1 and bubble=1, increment the 3-bit counter only when hold=0, and go to VECTOR after DRAIN_CYCLES counted cycles.
REQ-020 In VECTOR, for exactly one cycle, SHALL drive pc_load=1, pc_next=ISR_VECTOR and int_ack=1, clear pending, and go to ISR.
REQ-021 In ISR, SHALL hold in_isr=1 and all other control outputs 0; an interrupt only sets pending, giving no nesting.
REQ-022 In ISR with reti=1, SHALL go to RETURN.
REQ-023 In RETURN, for one cycle, SHALL drive pc_load=1, pc_next=epc and bubble=1 to squash the slot fetched after RETI, and go to RUN with in_isr=0.
REQ-024 After RETURN, SHALL set a settle flag so RUN lasts at least one cycle before a new entry, guaranteeing one instruction of forward progress.
REQ-025 reti outside ISR SHALL be ignored and cause no state change.
REQ-026 An interrupt and reti in the same cycle in ISR SHALL go to RETURN with pending=1, then enter DRAIN after the one settle cycle.
REQ-027 hold=1 during VECTOR or RETURN SHALL NOT extend those states, because the PC load is single-cycle.
REQ-028 pc_next SHALL be 8'h00 whenever pc_load=0.
REQ-029 Entry latency SHALL be 1 + DRAIN_CYCLES + 1 cycles from pending=1 in RUN to int_ack, plus any hold cycles.

Reset
REQ-030 While reset=0, SHALL force state RUN, pending=0, settle=0, counter=0, epc=8'h00 and all outputs 0, asynchronously.
REQ-031 Reset asserted mid-DRAIN, mid-ISR or mid-RETURN SHALL abandon the sequence with no pc_load pulse, and resume in RUN on the first clk edge after reset returns to 1.

Configuration
REQ-032 With macro INT_EDGE_EN defined, SHALL qualify interrupt on a 0->1 edge using a registered previous value that resets to 0; without it, SHALL qualify interrupt as level-high, so a held level re-enters the ISR after each RETURN plus the settle cycle.

Verification
REQ-033 reset=0 then 1, interrupt=0 for 10 cycles -> state RUN, all outputs 0, epc=8'h00.
REQ-034 current_address=8'h12, one-cycle interrupt pulse, hold=0 -> DRAIN for 3 cycles with stall_fetch=bubble=1, then int_ack with pc_load=1 and pc_next=8'hF0, in_isr=1, epc=8'h12.
REQ-035 As REQ-034 with hold=1 for 2 cycles mid-DRAIN -> DRAIN lasts 5 cycles, and int_ack arrives 2 cycles later.
REQ-036 In ISR, reti pulse -> one RETURN cycle with pc_load=1, pc_next=8'h12 and bubble=1, then RUN with in_isr=0.
REQ-037 interrupt and reti together in ISR -> RETURN, 1 RUN cycle, then DRAIN; with INT_EDGE_EN and interrupt held high after return -> no re-entry.
REQ-038 reset=0 during the 2nd DRAIN cycle -> outputs 0 immediately and no int_ack.
